alu_core: RTL and testbench

Sequential 8-bit arithmetic/logic stage directly upstream of the accumulator in the 8085 datapath. It latches the accumulator value and a bus operand, computes one of 16 operations, updates the 8085 flag register, and presents the result on `alu_out` with a one-cycle write-enable pulse for the accumulator. A start/busy/done handshake lets the control unit sequence it.

---
 rtl/i8085_pkg.sv | 22 ++
 rtl/alu_core_if.sv | 24 ++
 rtl/alu_flags_gen.sv | 56 +++++
 rtl/alu_core.sv | 142 ++++++++++++++
 tb/tb_alu_core.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/i8085_pkg.sv
// Shared 8085 datapath definitions: ALU op codes, flag bit positions, flag reset value.
package i8085_pkg;

  typedef enum logic [3:0] {
    OpAdd, OpAdc, OpSub, OpSbb, OpAna, OpXra, OpOra, OpCmp,
    OpInr, OpDcr, OpRlc, OpRrc, OpRal, OpRar, OpDaa, OpCma
  } alu_op_e;

  localparam int unsigned FlagS  = 7;
  localparam int unsigned FlagZ  = 6;
  localparam int unsigned FlagAc = 4;
  localparam int unsigned FlagP  = 2;
  localparam int unsigned FlagCy = 0;

  localparam logic [7:0] FlagsRst = 8'h02;

  // Bits 5 and 3 read as 0, bit 1 reads as 1 regardless of what is written.
  function automatic logic [7:0] fix_flags(input logic [7:0] f);
    return (f & 8'hD5) | 8'h02;
  endfunction

endpackage

// File: rtl/alu_core_if.sv
// Control-unit <-> ALU handshake, operand and result bundle.
interface alu_core_if;
  logic       start;
  logic [3:0] op;
  logic [7:0] acc_in;
  logic [7:0] bus_in;
  logic       flag_wr;
  logic [7:0] flag_in;
  logic [7:0] alu_out;
  logic       acc_we;
  logic [7:0] flags;
  logic       busy;
  logic       done;

  modport master (
    output start, op, acc_in, bus_in, flag_wr, flag_in,
    input  alu_out, acc_we, flags, busy, done
  );

  modport slave (
    input  start, op, acc_in, bus_in, flag_wr, flag_in,
    output alu_out, acc_we, flags, busy, done
  );
endinterface

// File: rtl/alu_flags_gen.sv
// Combinational 8085 flag generator: derives S/Z/P/AC/CY from result and adder carries.
module alu_flags_gen
  import i8085_pkg::*;
(
  input  alu_op_e    op_i,
  input  logic [7:0] res_i,
  input  logic       cout_i,
  input  logic       c4_i,
  input  logic [7:0] flags_i,
  output logic [7:0] flags_o
);

  logic [7:0] f;
  logic       szp;

  always_comb begin
    f   = flags_i;
    szp = 1'b0;
    unique case (op_i)
      OpAdd, OpAdc, OpDaa: begin
        szp       = 1'b1;
        f[FlagAc] = c4_i;
        f[FlagCy] = cout_i;
      end
      // Subtraction runs through the adder; CY reports borrow, the inverse of carry-out.
      OpSub, OpSbb, OpCmp: begin
        szp       = 1'b1;
        f[FlagAc] = c4_i;
        f[FlagCy] = ~cout_i;
      end
      OpAna: begin
        szp       = 1'b1;
        f[FlagAc] = c4_i;
        f[FlagCy] = 1'b0;
      end
      OpXra, OpOra: begin
        szp       = 1'b1;
        f[FlagAc] = 1'b0;
        f[FlagCy] = 1'b0;
      end
      OpInr, OpDcr: begin
        szp       = 1'b1;
        f[FlagAc] = c4_i;
      end
      OpRlc, OpRrc, OpRal, OpRar: f[FlagCy] = cout_i;
      OpCma: ;
    endcase
    if (szp) begin
      f[FlagS] = res_i[7];
      f[FlagZ] = (res_i == 8'h00);
      f[FlagP] = ~^res_i;
    end
    flags_o = fix_flags(f);
  end

endmodule

// File: rtl/alu_core.sv
// 8085 ALU stage: IDLE -> EXEC -> WB sequencer, operand latches, result and flag registers.
// ALU_DAA_EN enables decimal adjust on op E; otherwise op E completes as a no-op.
module alu_core
  import i8085_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  alu_core_if.slave  bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StWb   = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] act_q, tmp_q, alu_out_q, flags_q;
  alu_op_e    op_q;
  logic       acc_we_q, done_q;

  logic [7:0] add_a, add_b;
  logic       add_c;
  logic [8:0] sum;
  logic [4:0] sum_lo;
  logic [7:0] res;
  logic       cout, c4;
  logic [7:0] flags_new;
  logic       daa_nop;

  // Shared adder: subtracts as a + ~b + ~borrow; INR/DCR use TMP with +1 / +0xFE+1.
  always_comb begin
    add_a = act_q;
    add_b = tmp_q;
    add_c = 1'b0;
    case (op_q)
      OpAdc:        add_c = flags_q[FlagCy];
      OpSub, OpCmp: begin add_b = ~tmp_q; add_c = 1'b1; end
      OpSbb:        begin add_b = ~tmp_q; add_c = ~flags_q[FlagCy]; end
      OpInr:        begin add_a = tmp_q; add_b = 8'h00; add_c = 1'b1; end
      OpDcr:        begin add_a = tmp_q; add_b = 8'hFE; add_c = 1'b1; end
      default: ;
    endcase
  end

  assign sum    = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_c};
  assign sum_lo = {1'b0, add_a[3:0]} + {1'b0, add_b[3:0]} + {4'b0, add_c};

`ifdef ALU_DAA_EN
  logic       daa_lo, daa_hi;
  logic [4:0] daa_lo_sum;
  logic [7:0] daa_t;

  assign daa_lo     = (act_q[3:0] > 4'd9) | flags_q[FlagAc];
  assign daa_lo_sum = {1'b0, act_q[3:0]} + (daa_lo ? 5'd6 : 5'd0);
  assign daa_t      = act_q + (daa_lo ? 8'h06 : 8'h00);
  assign daa_hi     = (daa_t[7:4] > 4'd9) | flags_q[FlagCy];
  assign daa_nop    = 1'b0;
`else
  assign daa_nop    = (op_q == OpDaa);
`endif

  always_comb begin
    res  = sum[7:0];
    cout = sum[8];
    c4   = sum_lo[4];
    case (op_q)
      OpAna: begin res = act_q & tmp_q; c4 = act_q[3] | tmp_q[3]; end
      OpXra: res = act_q ^ tmp_q;
      OpOra: res = act_q | tmp_q;
      OpRlc: begin res = {act_q[6:0], act_q[7]}; cout = act_q[7]; end
      OpRrc: begin res = {act_q[0], act_q[7:1]}; cout = act_q[0]; end
      OpRal: begin res = {act_q[6:0], flags_q[FlagCy]}; cout = act_q[7]; end
      OpRar: begin res = {flags_q[FlagCy], act_q[7:1]}; cout = act_q[0]; end
`ifdef ALU_DAA_EN
      OpDaa: begin
        res  = daa_t + (daa_hi ? 8'h60 : 8'h00);
        cout = daa_hi;
        c4   = daa_lo_sum[4];
      end
`else
      OpDaa: res = alu_out_q;
`endif
      OpCma: res = ~act_q;
      default: ;
    endcase
  end

  alu_flags_gen u_flags_gen (
    .op_i    (op_q),
    .res_i   (res),
    .cout_i  (cout),
    .c4_i    (c4),
    .flags_i (flags_q),
    .flags_o (flags_new)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      act_q     <= 8'h00;
      tmp_q     <= 8'h00;
      op_q      <= OpAdd;
      alu_out_q <= 8'h00;
      flags_q   <= FlagsRst;
      acc_we_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (state_q == StIdle && bus.start) begin
        act_q <= bus.acc_in;
        tmp_q <= bus.bus_in;
        op_q  <= alu_op_e'(bus.op);
      end
      if (state_q == StExec) begin
        alu_out_q <= res;
        acc_we_q  <= (op_q != OpCmp) && !daa_nop;
        done_q    <= 1'b1;
        if (!daa_nop) flags_q <= flags_new;
      end
      // A POP PSW load overrides a same-cycle EXEC flag update.
      if (bus.flag_wr) flags_q <= fix_flags(bus.flag_in);
    end
  end

  assign bus.alu_out = alu_out_q;
  assign bus.acc_we  = acc_we_q;
  assign bus.flags   = flags_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed cases plus randomized ops against a reference model.
module tb_alu_core;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_core_if u_if ();

  alu_core u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] m_flags = 8'h02;
  logic [7:0] m_out   = 8'h00;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fixed(input logic [7:0] v);
    return {v[7], v[6], 1'b0, v[4], 1'b0, v[2], 1'b1, v[0]};
  endfunction

  // Reference model computed from the 8085 rules with integer arithmetic.
  function automatic void model(input int op, input int a, input int b, input logic [7:0] f,
                                input logic [7:0] prev, output logic [7:0] r,
                                output logic [7:0] nf, output bit we);
    int s, cin, cy, t;
    bit szp, lo, hi;
    logic fs, fz, fac, fp, fcy;
    fs = f[7]; fz = f[6]; fac = f[4]; fp = f[2]; fcy = f[0];
    cy = f[0] ? 1 : 0;
    r = prev; we = 1'b1; szp = 1'b0;
    case (op)
      0, 1: begin
        cin = (op == 1) ? cy : 0;
        s = a + b + cin; r = 8'(s);
        fcy = (s > 255); fac = ((a % 16 + b % 16 + cin) > 15); szp = 1'b1;
      end
      2, 3, 7: begin
        cin = (op == 3) ? cy : 0;
        s = a - b - cin; r = 8'(s);
        fcy = (s < 0); fac = ((a % 16 + (15 - b % 16) + (1 - cin)) > 15); szp = 1'b1;
        we = (op != 7);
      end
      4: begin r = 8'(a & b); fcy = 1'b0; fac = (((a | b) & 8) != 0); szp = 1'b1; end
      5: begin r = 8'(a ^ b); fcy = 1'b0; fac = 1'b0; szp = 1'b1; end
      6: begin r = 8'(a | b); fcy = 1'b0; fac = 1'b0; szp = 1'b1; end
      8: begin r = 8'(b + 1); fac = ((b % 16 + 1) > 15); szp = 1'b1; end
      9: begin r = 8'(b - 1); fac = ((b % 16 + 14 + 1) > 15); szp = 1'b1; end
      10: begin r = 8'(a * 2 + a / 128); fcy = (a >= 128); end
      11: begin r = 8'(a / 2 + (a % 2) * 128); fcy = (a % 2 == 1); end
      12: begin r = 8'(a * 2 + cy); fcy = (a >= 128); end
      13: begin r = 8'(a / 2 + cy * 128); fcy = (a % 2 == 1); end
      14: begin
`ifdef ALU_DAA_EN
        lo = (a % 16 > 9) || fac;
        fac = lo && (a % 16 + 6 > 15);
        t = (a + (lo ? 6 : 0)) % 256;
        hi = (t / 16 > 9) || fcy;
        t = (t + (hi ? 96 : 0)) % 256;
        fcy = hi;
        r = 8'(t); szp = 1'b1;
`else
        we = 1'b0;
`endif
      end
      default: r = 8'(255 - a);
    endcase
    if (szp) begin
      fs = r[7]; fz = (r == 8'h00); fp = ($countones(r) % 2 == 0);
    end
    nf = {fs, fz, 1'b0, fac, 1'b0, fp, 1'b1, fcy};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit fw_exec, input logic [7:0] fw_val);
    logic [7:0] e_res, e_fl;
    bit e_we;
    model(int'(op), int'(a), int'(b), m_flags, m_out, e_res, e_fl, e_we);
    if (fw_exec) e_fl = fixed(fw_val);
    @(negedge clk);
    u_if.start = 1'b1; u_if.op = op; u_if.acc_in = a; u_if.bus_in = b;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    chk("busy_exec", {7'b0, u_if.busy}, 8'h01);
    if (fw_exec) begin u_if.flag_wr = 1'b1; u_if.flag_in = fw_val; end
    @(posedge clk);
    #1 u_if.flag_wr = 1'b0;
    @(negedge clk);
    chk("done_wb", {7'b0, u_if.done}, 8'h01);
    chk("acc_we_wb", {7'b0, u_if.acc_we}, {7'b0, e_we});
    chk("alu_out", u_if.alu_out, e_res);
    chk("flags", u_if.flags, e_fl);
    @(negedge clk);
    chk("done_clr", {7'b0, u_if.done}, 8'h00);
    chk("acc_we_clr", {7'b0, u_if.acc_we}, 8'h00);
    chk("busy_idle", {7'b0, u_if.busy}, 8'h00);
    m_flags = e_fl;
    m_out   = e_res;
  endtask

  task automatic load_flags(input logic [7:0] v);
    @(negedge clk);
    u_if.flag_wr = 1'b1; u_if.flag_in = v;
    @(posedge clk);
    #1 u_if.flag_wr = 1'b0;
    m_flags = fixed(v);
    @(negedge clk);
    chk("flag_wr", u_if.flags, m_flags);
  endtask

  initial begin
    logic [7:0] done_vec, e_res, e_fl;
    bit e_we;
    u_if.start = 1'b0; u_if.op = 4'h0; u_if.acc_in = 8'h00; u_if.bus_in = 8'h00;
    u_if.flag_wr = 1'b0; u_if.flag_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_out", u_if.alu_out, 8'h00);
    chk("rst_flags", u_if.flags, 8'h02);
    chk("rst_acc_we", {7'b0, u_if.acc_we}, 8'h00);
    chk("rst_done", {7'b0, u_if.done}, 8'h00);
    chk("rst_busy", {7'b0, u_if.busy}, 8'h00);
    rst = 1'b0;

    run_op(4'h0, 8'h3A, 8'hC6, 1'b0, 8'h00);
    chk("add_out", u_if.alu_out, 8'h00);
    chk("add_flags", u_if.flags, 8'h57);
    run_op(4'h2, 8'h05, 8'h07, 1'b0, 8'h00);
    chk("sub_out", u_if.alu_out, 8'hFE);
    chk("sub_flags", u_if.flags, 8'h83);
    run_op(4'h7, 8'h10, 8'h10, 1'b0, 8'h00);
    chk("cmp_z", {7'b0, u_if.flags[6]}, 8'h01);

    load_flags(8'h00);
    chk("flags_clear", u_if.flags, 8'h02);
    run_op(4'hE, 8'h9B, 8'h00, 1'b0, 8'h00);
`ifdef ALU_DAA_EN
    chk("daa_out", u_if.alu_out, 8'h01);
    chk("daa_flags", u_if.flags, 8'h13);
`else
    chk("daa_nop_flags", u_if.flags, 8'h02);
`endif

    // start held for six edges: exactly two operations.
    model(0, 8'h11, 8'h22, m_flags, m_out, e_res, e_fl, e_we);
    done_vec = 8'h00;
    @(negedge clk);
    u_if.start = 1'b1; u_if.op = 4'h0; u_if.acc_in = 8'h11; u_if.bus_in = 8'h22;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1 if (c == 5) u_if.start = 1'b0;
      @(negedge clk);
      done_vec[c] = u_if.done;
    end
    chk("held_done", done_vec, 8'b0001_0010);
    m_flags = e_fl;
    model(0, 8'h11, 8'h22, m_flags, m_out, e_res, e_fl, e_we);
    m_flags = e_fl; m_out = e_res;
    chk("held_out", u_if.alu_out, m_out);
    chk("held_flags", u_if.flags, m_flags);

    run_op(4'h1, 8'h7F, 8'h01, 1'b1, 8'h80);
    chk("fw_exec_flags", u_if.flags, 8'h82);

    // Reset taken on the EXEC edge.
    @(negedge clk);
    u_if.start = 1'b1; u_if.op = 4'h0; u_if.acc_in = 8'h44; u_if.bus_in = 8'h55;
    @(posedge clk);
    #1 u_if.start = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_done", {7'b0, u_if.done}, 8'h00);
    chk("rst_exec_we", {7'b0, u_if.acc_we}, 8'h00);
    chk("rst_exec_busy", {7'b0, u_if.busy}, 8'h00);
    chk("rst_exec_flags", u_if.flags, 8'h02);
    chk("rst_exec_out", u_if.alu_out, 8'h00);
    @(negedge clk);
    chk("rst_exec_done2", {7'b0, u_if.done}, 8'h00);
    m_flags = 8'h02; m_out = 8'h00;

    load_flags(8'hFF);
    chk("flag_wr_ff", u_if.flags, 8'hD7);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) load_flags(8'($urandom));
      run_op(4'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0),
             8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
